// File: rtl/decode_stage_pkg.sv
// Shared decode package: opcode set, instruction field positions, decoded bundle and buffer states.
package decode_stage_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_ADD    = 4'h1,
    OP_SUB    = 4'h2,
    OP_AND    = 4'h3,
    OP_OR     = 4'h4,
    OP_XOR    = 4'h5,
    OP_ADDI   = 4'h6,
    OP_ANDI   = 4'h7,
    OP_ORI    = 4'h8,
    OP_LD     = 4'h9,
    OP_ST     = 4'hA,
    OP_BEQ    = 4'hB,
    OP_LDI    = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_RSVD_F = 4'hF
  } opcode_e;

  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 9;
  localparam int unsigned RS_HI  = 8;
  localparam int unsigned RS_LO  = 6;
  localparam int unsigned RT_HI  = 5;
  localparam int unsigned RT_LO  = 3;
  localparam int unsigned IMM_HI = 5;
  localparam int unsigned IMM_LO = 0;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [5:0] imm6;
    logic       cs;
    logic       use_imm;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       illegal;
    logic [7:0] pc;
  } dec_t;

  localparam int unsigned DEC_W = 34;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_e;

endpackage

// File: rtl/decode_stage_table.sv
// Pure opcode-to-control decode table.
// Opcodes D-F raise illegal only when DECODE_ILLEGAL_TRAP_EN is defined; otherwise they decode as NOP.
module decode_table
  import decode_stage_pkg::*;
(
  input  logic [15:0] instr_i,
  input  logic [7:0]  pc_i,
  output dec_t        dec_o
);

  logic [DEC_W-1:0] bundle;
  dec_t             d;

  assign bundle = d;
  assign dec_o  = dec_t'(bundle);

  always_comb begin
    d        = '0;
    d.opcode = instr_i[OPC_HI:OPC_LO];
    d.rd     = instr_i[RD_HI:RD_LO];
    d.rs     = instr_i[RS_HI:RS_LO];
    d.rt     = instr_i[RT_HI:RT_LO];
    d.imm6   = instr_i[IMM_HI:IMM_LO];
    d.pc     = pc_i;
    case (opcode_e'(instr_i[OPC_HI:OPC_LO]))
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: d.reg_we = 1'b1;
      OP_ADDI: begin
        d.reg_we  = 1'b1;
        d.use_imm = 1'b1;
        d.cs      = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_LDI: begin
        d.reg_we  = 1'b1;
        d.use_imm = 1'b1;
      end
      OP_LD: begin
        d.reg_we  = 1'b1;
        d.mem_rd  = 1'b1;
        d.use_imm = 1'b1;
        d.cs      = 1'b1;
      end
      OP_ST: begin
        d.mem_wr  = 1'b1;
        d.use_imm = 1'b1;
        d.cs      = 1'b1;
      end
      OP_BEQ: begin
        d.branch  = 1'b1;
        d.use_imm = 1'b1;
        d.cs      = 1'b1;
      end
      OP_RSVD_D, OP_RSVD_E, OP_RSVD_F: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        d.illegal = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes at the input and holds results in a 2-entry skid buffer (oldest on outputs).
// Illegal-opcode trapping is selected by DECODE_ILLEGAL_TRAP_EN (see decode_table).
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic [7:0]  in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_pc,
  output logic [3:0]  out_opcode,
  output logic [2:0]  out_rd,
  output logic [2:0]  out_rs,
  output logic [2:0]  out_rt,
  output logic [5:0]  out_imm6,
  output logic        out_cs,
  output logic        out_use_imm,
  output logic        out_reg_we,
  output logic        out_mem_rd,
  output logic        out_mem_wr,
  output logic        out_branch,
  output logic        out_illegal
);

  dec_t             dec_in;
  dec_t             head;
  logic [DEC_W-1:0] head_q;
  logic [DEC_W-1:0] tail_q;
  state_e           state_q;
  logic             accept;
  logic             retire;

  decode_table u_table (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .dec_o   (dec_in)
  );

  // Valid is masked during rst/flush so the consumer never sees a handshake on a discarded entry.
  assign in_ready  = !rst && (state_q != S_TWO);
  assign out_valid = !rst && !flush && (state_q != S_EMPTY);
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      state_q <= S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            head_q  <= dec_in;
            state_q <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && retire) begin
            head_q <= dec_in;
          end else if (accept) begin
            tail_q  <= dec_in;
            state_q <= S_TWO;
          end else if (retire) begin
            state_q <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (retire) begin
            head_q  <= tail_q;
            state_q <= S_ONE;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign head        = dec_t'(head_q);
  assign out_pc      = head.pc;
  assign out_opcode  = head.opcode;
  assign out_rd      = head.rd;
  assign out_rs      = head.rs;
  assign out_rt      = head.rt;
  assign out_imm6    = head.imm6;
  assign out_cs      = head.cs;
  assign out_use_imm = head.use_imm;
  assign out_reg_we  = head.reg_we  && out_valid;
  assign out_mem_rd  = head.mem_rd  && out_valid;
  assign out_mem_wr  = head.mem_wr  && out_valid;
  assign out_branch  = head.branch  && out_valid;
  assign out_illegal = head.illegal && out_valid;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a queue-based FIFO model predicts each presented instruction.
module tb_decode_stage;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic [7:0]  in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_pc;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rd, out_rs, out_rt;
  logic [5:0]  out_imm6;
  logic        out_cs, out_use_imm, out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_illegal;

  decode_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_imm6(out_imm6), .out_cs(out_cs), .out_use_imm(out_use_imm),
    .out_reg_we(out_reg_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_branch(out_branch), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] rd, rs, rt;
    logic [5:0] imm6;
    logic       cs, use_imm, reg_we, mem_rd, mem_wr, branch, illegal;
    logic [7:0] pc;
  } exp_t;

  // Per-opcode controls {use_imm, reg_we, mem_rd, mem_wr, branch, cs} from the instruction-set table.
  logic [5:0] ctl_tab [16] = '{
    6'b000000, 6'b010000, 6'b010000, 6'b010000, 6'b010000, 6'b010000,
    6'b110001, 6'b110000, 6'b110000, 6'b111001, 6'b100101, 6'b100011,
    6'b110000, 6'b000000, 6'b000000, 6'b000000};

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  logic exp_ready = 1'b0;
  logic mon_en = 1'b0;

  function automatic exp_t ref_decode(input logic [15:0] ins, input logic [7:0] pc);
    exp_t        e;
    logic [5:0]  c;
    int unsigned op;
    op        = int'(ins[15:12]);
    c         = ctl_tab[op];
    e.opcode  = ins[15:12];
    e.rd      = ins[11:9];
    e.rs      = ins[8:6];
    e.rt      = ins[5:3];
    e.imm6    = ins[5:0];
    e.use_imm = c[5];
    e.reg_we  = c[4];
    e.mem_rd  = c[3];
    e.mem_wr  = c[2];
    e.branch  = c[1];
    e.cs      = c[0];
    e.illegal = TRAP && (op >= 13);
    e.pc      = pc;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, compares the presented entry to the oldest expected one.
  always @(negedge clk) begin
    logic exp_valid;
    exp_t act;
    if (mon_en) begin
      exp_valid = !rst && !flush && (sb.size() > 0);
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("out_valid", 64'(out_valid), 64'(exp_valid));
      act = {out_opcode, out_rd, out_rs, out_rt, out_imm6, out_cs, out_use_imm,
             out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_illegal, out_pc};
      if (exp_valid) begin
        check("bundle", 64'(act), 64'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end else begin
        check("idle_ctl", 64'({out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_illegal}), 64'(0));
      end
    end
  end

  task automatic cycle(input logic v, input logic [15:0] ins, input logic [7:0] pc,
                       input logic fl, input logic ordy, input logic r);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    flush     = fl;
    out_ready = ordy;
    rst       = r;
    exp_ready = !r && (sb.size() < 2);
    @(posedge clk);
    #1;
    if (r || fl) sb.delete();
    else if (v && exp_ready) sb.push_back(ref_decode(ins, pc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) cycle(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    check("rst_fields", 64'({out_opcode, out_rd, out_rs, out_rt, out_imm6, out_cs, out_use_imm, out_pc}), 64'(0));
    cycle(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0);

    cycle(1'b1, 16'h6A3F, 8'h10, 1'b0, 1'b1, 1'b0);
    check("addi_valid", 64'(out_valid), 64'(1));
    check("addi_rd", 64'(out_rd), 64'(5));
    check("addi_imm6", 64'(out_imm6), 64'h3F);
    check("addi_cs", 64'(out_cs), 64'(1));
    check("addi_use_imm", 64'(out_use_imm), 64'(1));
    check("addi_reg_we", 64'(out_reg_we), 64'(1));
    cycle(1'b1, 16'h7A3F, 8'h11, 1'b0, 1'b1, 1'b0);
    check("andi_cs", 64'(out_cs), 64'(0));
    check("andi_imm6", 64'(out_imm6), 64'h3F);
    check("andi_reg_we", 64'(out_reg_we), 64'(1));
    cycle(1'b1, 16'hE000, 8'h12, 1'b0, 1'b1, 1'b0);
    check("ill_flag", 64'(out_illegal), 64'(TRAP));
    check("ill_ctl", 64'({out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_use_imm, out_cs}), 64'(0));
    cycle(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);

    cycle(1'b1, 16'h1111, 8'h20, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h2222, 8'h21, 1'b0, 1'b0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'(0));
    cycle(1'b1, 16'h3333, 8'h22, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h3333, 8'h22, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 16'h3333, 8'h22, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);

    cycle(1'b1, 16'h9123, 8'h30, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hA456, 8'h31, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hB789, 8'h32, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    check("flush_empty", 64'(out_valid), 64'(0));
    cycle(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);

    cycle(1'b1, 16'hC0FF, 8'h40, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h8ABC, 8'h41, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 8'($urandom),
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) == 0);
    end
    repeat (4) cycle(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state changes on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: in_valid in 1, in_ready out 1, in_instr in 16, in_pc in 8  (fetch-side handshake).
REQ-004 SHALL have ports: flush  in  1  discard all buffered instructions.
REQ-005 SHALL have ports: out_valid out 1, out_ready in 1, out_pc out 8  (execute-side handshake).
REQ-006 SHALL have ports: out_opcode out 4, out_rd out 3, out_rs out 3, out_rt out 3  (decoded fields).
REQ-007 SHALL have ports: out_imm6 out 6, out_cs out 1  (raw immediate and sign-extend select for the constant unit; 1 = sign-extend, 0 = zero-extend).
REQ-008 SHALL have ports: out_use_imm, out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_illegal  out  1 each.

Function
REQ-009 SHALL slice in_instr as opcode[15:12], rd[11:9], rs[8:6], rt[5:3], imm6[5:0].
REQ-010 SHALL decode: 0 NOP; 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR (reg_we); 6 ADDI (reg_we, use_imm, cs=1); 7 ANDI, 8 ORI (reg_we, use_imm, cs=0); 9 LD (reg_we, mem_rd, use_imm, cs=1); A ST (mem_wr, use_imm, cs=1); B BEQ (branch, use_imm, cs=1); C LDI (reg_we, use_imm, cs=0); D-F illegal.
REQ-011 SHALL decode combinationally at the input and store decoded results in a 2-entry skid buffer.
REQ-012 SHALL transfer on in_valid&in_ready (accept) and on out_valid&out_ready (retire).
REQ-013 SHALL present an instruction accepted in cycle N on the outputs in cycle N+1 when the buffer was empty.
REQ-014 SHALL implement states EMPTY, ONE, TWO: EMPTY->ONE on accept; ONE->TWO on accept without retire; ONE->EMPTY on retire without accept; ONE->ONE on both; TWO->ONE on retire.
REQ-015 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO and while rst is high.
REQ-016 SHALL retire in strict FIFO order; the oldest entry is always on the outputs.
REQ-017 SHALL hold all out_* fields stable while out_valid=1 and out_ready=0.
REQ-018 SHALL force out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_illegal to 0 while out_valid=0.
REQ-019 SHALL, on flush, go to EMPTY next cycle; flush overrides a same-cycle accept (instruction dropped) and retire.
REQ-020 SHALL pass in_pc through unchanged alongside its instruction.

Reset
REQ-021 SHALL on rst: state EMPTY, out_valid=0, all out_* fields 0, in_ready=0; in_ready=1 the first cycle after rst deasserts.
REQ-022 SHALL treat rst mid-operation as flush: buffered instructions discarded, none retired.

Configuration
REQ-023 SHALL support macro DECODE_ILLEGAL_TRAP_EN.
REQ-024 SHALL, with DECODE_ILLEGAL_TRAP_EN defined, emit opcodes D-F with out_illegal=1 and all other control bits 0.
REQ-025 SHALL, without DECODE_ILLEGAL_TRAP_EN, decode opcodes D-F as NOP with out_illegal tied 0.

Structure
REQ-026 SHALL place opcode constants, field bit positions and the decoded-bundle width in the shared CPU package.
REQ-027 SHALL split the pure opcode-to-control table into sub-module decode_table; decode_stage holds only the skid buffer and handshake.

Verification
REQ-028 SHALL verify: reset, then in_instr=16'h6A3F (ADDI rd=5 rs=0 imm=3F) valid one cycle -> next cycle out_valid=1, out_rd=5, out_imm6=6'h3F, out_cs=1, out_use_imm=1, out_reg_we=1.
REQ-029 SHALL verify: in_instr=16'h7A3F (ANDI) -> out_cs=0, out_imm6=6'h3F, out_reg_we=1.
REQ-030 SHALL verify: out_ready=0, three back-to-back valid instructions -> first two accepted, in_ready=0 after second; release out_ready -> retire in order, third then accepted.
REQ-031 SHALL verify: buffer in TWO, flush with in_valid=1 -> next cycle out_valid=0, state EMPTY, no instruction retired.
REQ-032 SHALL verify: in_instr=16'hE000 -> out_illegal=1 with DECODE_ILLEGAL_TRAP_EN; out_illegal=0, all controls 0 without.
REQ-033 SHALL verify: rst asserted with entries buffered -> out_valid=0, in_ready=0 during rst, in_ready=1 one cycle after release.
